// File: rtl/multiplier_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the arithmetic processor datapath blocks (multiplier
// and divider): default operand width, FSM state encoding and the helper
// used to size iteration counters.
// No ports (package).
// ---------------------------------------------------------------------------
package arith_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // Both sequential arithmetic units walk through the same three phases:
   // wait for a request, iterate, then apply the result sign.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SIGN = 2'd2
   } arithState_e;

   // Smallest r with 2**r >= value; used as clog2(WIDTH+1) so a counter can
   // hold the value WIDTH itself.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/multiplier_if.sv
// ---------------------------------------------------------------------------
// multiplier_if
// start/ready request bus shared by the sequential multiplier and divider.
// Signals:
//   multiplicand  WIDTH     signed operand A (master -> slave)
//   multiplier    WIDTH     signed operand B (master -> slave)
//   start         1         request, accepted when ready && start
//   product       2*WIDTH   signed result (slave -> master)
//   ready         1         1 = idle and result stable (slave -> master)
// Modports: master (requester), slave (arithmetic unit).
// ---------------------------------------------------------------------------
interface multiplier_if
   import arith_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH) ();

   logic [WIDTH-1:0]   multiplicand;
   logic [WIDTH-1:0]   multiplier;
   logic               start;
   logic [2*WIDTH-1:0] product;
   logic               ready;

   modport master (
      output multiplicand,
      output multiplier,
      output start,
      input  product,
      input  ready
   );

   modport slave (
      input  multiplicand,
      input  multiplier,
      input  start,
      output product,
      output ready
   );

endinterface

// File: rtl/multiplier_mag.sv
// ---------------------------------------------------------------------------
// twos_magnitude
// Splits a two's-complement value into an unsigned magnitude and a sign bit.
// The most negative value maps to magnitude 2**(WIDTH-1), which still fits
// in WIDTH unsigned bits, so there is no overflow case.
// Ports:
//   value_i  in   WIDTH  two's-complement input
//   mag_o    out  WIDTH  unsigned |value_i|
//   sign_o   out  1      1 when value_i is negative
// ---------------------------------------------------------------------------
module twos_magnitude
   import arith_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH)
   (
      input  logic [WIDTH-1:0] value_i,
      output logic [WIDTH-1:0] mag_o,
      output logic             sign_o
   );

   // Negation is done modulo 2**WIDTH, which yields the correct unsigned
   // magnitude even for the most negative input.
   always_comb begin
      sign_o = value_i[WIDTH-1];
      mag_o  = sign_o ? ('0 - value_i) : value_i;
   end

endmodule

// File: rtl/multiplier.sv
// ---------------------------------------------------------------------------
// multiplier
// Sequential signed shift-add multiplier. Operands are converted to
// magnitudes on the accept edge, one partial-product step is done per clock
// for WIDTH clocks, and the sign is applied on a final edge. The product
// register only changes on that final edge, so it never shows partial sums.
// Ports:
//   clk   in     1   rising-edge clock
//   rst   in     1   asynchronous reset, active high
//   bus   slave      start/ready request bus (operands, product, ready)
// ---------------------------------------------------------------------------
module multiplier
   import arith_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH)
   (
      input  logic         clk,
      input  logic         rst,
      multiplier_if.slave  bus
   );

   localparam int CW = clog2(WIDTH + 1);
   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
   localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

   arithState_e        state_q;
   logic [WIDTH-1:0]   magA_q;
   logic [WIDTH-1:0]   magB_q;
   logic               neg_q;
   logic [2*WIDTH:0]   acc_q;
   logic [CW-1:0]      count_q;
   logic [2*WIDTH-1:0] product_q;

   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic               signA;
   logic               signB;

   logic [WIDTH:0]     upperSum;
   logic [2*WIDTH:0]   acc_d;
   logic [2*WIDTH-1:0] accLow;
   logic [2*WIDTH-1:0] product_d;

   twos_magnitude #(.WIDTH(WIDTH)) uMagA (
      .value_i (bus.multiplicand),
      .mag_o   (magA),
      .sign_o  (signA)
   );

   twos_magnitude #(.WIDTH(WIDTH)) uMagB (
      .value_i (bus.multiplier),
      .mag_o   (magB),
      .sign_o  (signB)
   );

   // One shift-add step: the upper half of the accumulator (with a spare
   // carry bit) absorbs the multiplicand when the current multiplier bit is
   // set, then the whole accumulator shifts right. After WIDTH steps the
   // low 2*WIDTH bits hold the unsigned product of the magnitudes.
   always_comb begin
      upperSum  = acc_q[2*WIDTH:WIDTH] + (magB_q[0] ? {1'b0, magA_q} : '0);
      acc_d     = {upperSum, acc_q[WIDTH-1:0]} >> 1;
      accLow    = acc_q[2*WIDTH-1:0];
      product_d = neg_q ? ('0 - accLow) : accLow;
   end

   // Control and datapath in one register block. Requests are only looked
   // at in IDLE, so start pulses and operand changes while busy are ignored.
   // Negating a zero magnitude gives zero, so no negative zero can appear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         magA_q    <= '0;
         magB_q    <= '0;
         neg_q     <= 1'b0;
         acc_q     <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  magA_q  <= magA;
                  magB_q  <= magB;
                  neg_q   <= signA ^ signB;
                  acc_q   <= '0;
                  count_q <= COUNT_INIT;
                  state_q <= RUN;
               end
            end
            RUN: begin
               acc_q   <= acc_d;
               magB_q  <= magB_q >> 1;
               count_q <= count_q - COUNT_ONE;
               if (count_q == COUNT_ONE) begin
                  state_q <= SIGN;
               end
            end
            SIGN: begin
               product_q <= product_d;
               state_q   <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // ready is a pure decode of the state register.
   always_comb begin
      bus.ready   = (state_q == IDLE);
      bus.product = product_q;
   end

endmodule
